lcd_debug_writer: RTL and testbench
===================================

// Module: lcd_debug_writer
// PURPOSE
//  Drives the board's 16x2 HD44780 character LCD in 8-bit write-only mode.
//  Sits downstream of SYS_Master's debug mux and consumes its debug data word,
//  the current PC and the output-select code.
//  On each refresh request it takes a snapshot of those values and draws:
//    line 1 = "PC " + PC as hex, line 2 = "S" + SEL as hex + ": " + DATA as hex.
//  Owns the power-up wait, the controller init sequence and all LCD bus timing.
// PARAMETERS
//  PWRUP_CYCLES  750000  clocks to wait after reset before the first command (15 ms @ 50 MHz)
//  EN_CYCLES     25      clocks LCD_EN is held high per byte (500 ns)
//  CMD_WAIT      2500    clocks of idle after each byte other than 0x01 (50 us)
//  CLR_WAIT      100000  clocks of idle after the clear command 0x01 (2 ms)
// PORTS
//  CLOCK_50   in   1   single clock; all logic on the rising edge
//  SYS_reset  in   1   synchronous, active-high reset
//  upd_req    in   1   one-cycle pulse: request a redraw
//  DATA       in   32  debug word to display
//  PC         in   32  program counter to display
//  SEL        in   8   debug output-select code to display
//  busy       out  1   high during power-up, init or a redraw
//  ready      out  1   high once init is complete (stays high until reset)
//  LCD_DATA   out  8   LCD data bus
//  LCD_RS     out  1   0 = command byte, 1 = character byte
//  LCD_RW     out  1   held at constant 0
//  LCD_EN     out  1   enable strobe; the LCD latches on its falling edge
// BEHAVIOUR
//  Reset values (first edge with SYS_reset=1):
//   - LCD_DATA=8'h00, LCD_RS=0, LCD_RW=0, LCD_EN=0.
//   - busy=1, ready=0; pending flag and snapshot registers cleared.
//   - FSM in PWR_WAIT with its counter at 0.
//  Reset mid-operation: abort at once and drop any in-flight byte.
//   LCD_EN=0 from the next edge, then power-up and init restart.
//  FSM states:
//   - PWR_WAIT: count PWRUP_CYCLES clocks, then go to INIT.
//   - INIT: send commands 38,0C,01,06 in order, then go to IDLE.
//   - IDLE: if pending, capture DATA/PC/SEL into the snapshot and clear pending.
//   - L1A: send 0x80. L1C: send 16 characters.
//   - L2A: send 0xC0. L2C: send 16 characters. Then return to IDLE.
//  Byte transfer sub-sequence:
//   - SETUP (1 clk): LCD_RS and LCD_DATA driven, EN=0.
//   - STROBE (EN_CYCLES clks): EN=1; RS and DATA stay stable.
//   - HOLD (CMD_WAIT or CLR_WAIT clks): EN=0; RS and DATA stay stable.
//   - Cycles per byte = 1 + EN_CYCLES + wait. RS=0 for commands, RS=1 for characters.
//  Line 1 characters: "PC " + PC[31:28]..PC[3:0] + 5 spaces (3+8+5 = 16).
//  Line 2 characters: "S" + SEL[7:4],SEL[3:0] + ":" + " " + DATA nibbles, MSB first,
//   + 3 spaces (1+2+1+1+8+3 = 16).
//  Nibble to ASCII: 0-9 map to 8'h30+n; A-F map to 8'h41+(n-10) (uppercase).
//  The snapshot is frozen for the whole redraw; input changes during it are ignored.
//  upd_req handling:
//   - Sets the pending flag in any state, including PWR_WAIT and INIT.
//   - Multiple requests before service collapse into one redraw.
//   - A request arriving on the same edge the snapshot is taken is serviced by that redraw.
//  busy is 0 only in IDLE with pending=0. ready goes to 1 on entering IDLE after INIT.
//  Inputs are sampled only at snapshot time, so no other input handshake is needed.
// TESTING (bench params: PWRUP=10, EN=2, CMD_WAIT=4, CLR_WAIT=8)
//  1. Release reset -> no EN pulse for 10 clocks.
//     Then four EN pulses with RS=0 and DATA 38,0C,01,06.
//     Pulse spacing is 7 clocks, except 11 clocks after the 01. ready=1 afterwards.
//  2. PC=0040001C, SEL=07, DATA=0040001C, pulse upd_req ->
//     byte 80, then "PC 0040001C     " (RS=1),
//     byte C0, then "S07: 0040001C   ". 34 bytes in total, then busy=0.
//  3. DATA=DEADBEEF, SEL=0B, redraw ->
//     line-2 bytes 53 30 42 3A 20 44 45 41 44 42 45 45 46 20 20 20.
//  4. Change PC and DATA every clock during a redraw ->
//     the displayed text matches the values at the snapshot edge.
//  5. Three upd_req pulses during a redraw -> exactly one further redraw, then IDLE.
//  6. Assert SYS_reset during L1C with EN=1 ->
//     EN=0 and busy=1 on the next edge, ready=0, init sequence repeats as in test 1.

Source files
------------

// File: rtl/lcd_debug_writer.sv
// ---------------------------------------------------------------------------
// lcd_debug_writer
//   Drives a 16x2 HD44780 character LCD in 8-bit write-only mode. After the
//   power-up wait and the controller init sequence, each redraw request takes
//   a snapshot of PC / SEL / DATA and paints:
//     line 1: "PC " + 8 hex digits of PC + 5 spaces
//     line 2: "S" + 2 hex digits of SEL + ": " + 8 hex digits of DATA + 3 spaces
//
// Ports
//   CLOCK_50   in   single clock, rising edge
//   SYS_reset  in   synchronous, active-high reset
//   upd_req    in   one-cycle redraw request
//   DATA       in   32-bit debug word
//   PC         in   32-bit program counter
//   SEL        in   8-bit debug output-select code
//   busy       out  high unless idle with no redraw pending
//   ready      out  high once the init sequence has completed
//   LCD_DATA   out  LCD data bus
//   LCD_RS     out  0 = command, 1 = character
//   LCD_RW     out  tied low (write only)
//   LCD_EN     out  enable strobe; the LCD latches on its falling edge
// ---------------------------------------------------------------------------
module lcd_debug_writer #(
    parameter int PWRUP_CYCLES = 750000,
    parameter int EN_CYCLES    = 25,
    parameter int CMD_WAIT     = 2500,
    parameter int CLR_WAIT     = 100000
) (
    input  logic        CLOCK_50,
    input  logic        SYS_reset,
    input  logic        upd_req,
    input  logic [31:0] DATA,
    input  logic [31:0] PC,
    input  logic [7:0]  SEL,
    output logic        busy,
    output logic        ready,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic        LCD_EN
);

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_L1A,
        ST_L1C,
        ST_L2A,
        ST_L2C
    } state_e;

    // Per-byte sub-sequence: one setup clock, EN strobe, then EN-low hold.
    typedef enum logic [1:0] {
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } phase_e;

    localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_CYCLES - 1);
    localparam logic [31:0] EN_LAST    = 32'(EN_CYCLES - 1);
    localparam logic [31:0] CMD_LAST   = 32'(CMD_WAIT - 1);
    localparam logic [31:0] CLR_LAST   = 32'(CLR_WAIT - 1);

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        pend_q, pend_d;
    logic        ready_q, ready_d;
    logic [31:0] snap_pc_q, snap_pc_d;
    logic [31:0] snap_data_q, snap_data_d;
    logic [7:0]  snap_sel_q, snap_sel_d;
    logic [7:0]  lcd_data_q, lcd_data_d;
    logic        lcd_rs_q, lcd_rs_d;
    logic        lcd_en_q, lcd_en_d;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        // 0x37 + 10 = 'A', so one offset covers the whole A-F range.
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [63:0] hex_word(input logic [31:0] v);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[63 - 8*i -: 8] = hex_ascii(v[31 - 4*i -: 4]);
        end
        return r;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h38;  // 8-bit bus, 2 lines, 5x8 font
            4'd1:    return 8'h0C;  // display on, cursor off
            4'd2:    return 8'h01;  // clear display
            default: return 8'h06;  // entry mode: increment, no shift
        endcase
    endfunction

    // Both text lines are pure functions of the frozen snapshot.
    logic [127:0] line1, line2;
    assign line1 = {8'h50, 8'h43, 8'h20, hex_word(snap_pc_q), {5{8'h20}}};
    assign line2 = {8'h53, hex_ascii(snap_sel_q[7:4]), hex_ascii(snap_sel_q[3:0]),
                    8'h3A, 8'h20, hex_word(snap_data_q), {3{8'h20}}};

    logic         byte_done;
    logic         sending_d;
    logic [7:0]   next_byte;
    logic [127:0] line_sh;
    logic [31:0]  hold_last;

    // The clear command needs the long settle time; every other byte the short one.
    assign hold_last = (!lcd_rs_q && lcd_data_q == 8'h01) ? CLR_LAST : CMD_LAST;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (which would infer a latch).
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        ready_d     = ready_q;
        snap_pc_d   = snap_pc_q;
        snap_data_d = snap_data_q;
        snap_sel_d  = snap_sel_q;
        lcd_data_d  = lcd_data_q;
        lcd_rs_d    = lcd_rs_q;
        byte_done   = 1'b0;
        next_byte   = 8'h00;
        line_sh     = '0;

        // Requests accumulate in any state; several collapse into one redraw.
        pend_d = pend_q | upd_req;

        case (state_q)
            ST_PWR_WAIT: begin
                if (cnt_q == PWRUP_LAST) begin
                    state_d = ST_INIT;
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            ST_IDLE: begin
                if (pend_q) begin
                    snap_pc_d   = PC;
                    snap_data_d = DATA;
                    snap_sel_d  = SEL;
                    // A request on this same edge is covered by this redraw.
                    pend_d      = 1'b0;
                    state_d     = ST_L1A;
                    phase_d     = PH_SETUP;
                    cnt_d       = '0;
                    idx_d       = '0;
                end
            end

            default: begin
                case (phase_q)
                    PH_SETUP: begin
                        phase_d = PH_STROBE;
                        cnt_d   = '0;
                    end
                    PH_STROBE: begin
                        if (cnt_q == EN_LAST) begin
                            phase_d = PH_HOLD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                    default: begin
                        if (cnt_q == hold_last) begin
                            byte_done = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                endcase

                if (byte_done) begin
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                    case (state_q)
                        ST_INIT: begin
                            if (idx_q == 4'd3) begin
                                state_d = ST_IDLE;
                                ready_d = 1'b1;
                            end else begin
                                idx_d = idx_q + 4'd1;
                            end
                        end
                        ST_L1A: begin
                            state_d = ST_L1C;
                            idx_d   = '0;
                        end
                        ST_L1C: begin
                            if (idx_q == 4'd15) begin
                                state_d = ST_L2A;
                            end
                            idx_d = idx_q + 4'd1;  // wraps to 0 for the next state
                        end
                        ST_L2A: begin
                            state_d = ST_L2C;
                            idx_d   = '0;
                        end
                        default: begin  // ST_L2C
                            if (idx_q == 4'd15) begin
                                state_d = ST_IDLE;
                            end
                            idx_d = idx_q + 4'd1;
                        end
                    endcase
                end
            end
        endcase

        // Bus outputs are registered: the byte is loaded on the edge entering
        // SETUP and held unchanged through STROBE and HOLD.
        sending_d = (state_d != ST_PWR_WAIT) && (state_d != ST_IDLE);
        case (state_d)
            ST_INIT: next_byte = init_cmd(idx_d);
            ST_L1A:  next_byte = 8'h80;
            ST_L1C: begin
                line_sh   = line1 << {idx_d, 3'b000};
                next_byte = line_sh[127:120];
            end
            ST_L2A:  next_byte = 8'hC0;
            ST_L2C: begin
                line_sh   = line2 << {idx_d, 3'b000};
                next_byte = line_sh[127:120];
            end
            default: next_byte = 8'h00;
        endcase

        if (sending_d && phase_d == PH_SETUP) begin
            lcd_data_d = next_byte;
            lcd_rs_d   = (state_d == ST_L1C) || (state_d == ST_L2C);
        end
        lcd_en_d = sending_d && (phase_d == PH_STROBE);
    end

    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (SYS_reset) begin
            state_q     <= ST_PWR_WAIT;
            phase_q     <= PH_SETUP;
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            ready_q     <= 1'b0;
            // NOTE: the snapshot is only a few registers, so it is cleared with the rest rather than left unreset like a RAM.
            snap_pc_q   <= '0;
            snap_data_q <= '0;
            snap_sel_q  <= '0;
            lcd_data_q  <= 8'h00;
            lcd_rs_q    <= 1'b0;
            lcd_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            ready_q     <= ready_d;
            snap_pc_q   <= snap_pc_d;
            snap_data_q <= snap_data_d;
            snap_sel_q  <= snap_sel_d;
            lcd_data_q  <= lcd_data_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_en_q    <= lcd_en_d;
        end
    end

    assign busy     = !((state_q == ST_IDLE) && !pend_q);
    assign ready    = ready_q;
    assign LCD_DATA = lcd_data_q;
    assign LCD_RS   = lcd_rs_q;
    assign LCD_RW   = 1'b0;
    assign LCD_EN   = lcd_en_q;

endmodule

// File: tb/tb_lcd_debug_writer.sv
// ---------------------------------------------------------------------------
// tb_lcd_debug_writer
//   Directed bench for lcd_debug_writer with short timing parameters
//   (PWRUP=10, EN=2, CMD_WAIT=4, CLR_WAIT=8). A monitor logs every byte the
//   LCD would latch (EN falling edge) together with its clock index; the
//   checks compare that log against hand-written expected tables.
// ---------------------------------------------------------------------------
module tb_lcd_debug_writer;

    logic        CLOCK_50 = 1'b0;
    logic        SYS_reset;
    logic        upd_req;
    logic [31:0] DATA;
    logic [31:0] PC;
    logic [7:0]  SEL;
    logic        busy;
    logic        ready;
    logic [7:0]  LCD_DATA;
    logic        LCD_RS;
    logic        LCD_RW;
    logic        LCD_EN;

    lcd_debug_writer #(
        .PWRUP_CYCLES(10),
        .EN_CYCLES   (2),
        .CMD_WAIT    (4),
        .CLR_WAIT    (8)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .SYS_reset(SYS_reset),
        .upd_req  (upd_req),
        .DATA     (DATA),
        .PC       (PC),
        .SEL      (SEL),
        .busy     (busy),
        .ready    (ready),
        .LCD_DATA (LCD_DATA),
        .LCD_RS   (LCD_RS),
        .LCD_RW   (LCD_RW),
        .LCD_EN   (LCD_EN)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // ---------------- byte monitor ----------------
    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         cyc;
    } rec_t;

    rec_t mon_q[$];
    int   cyc     = 0;
    logic prev_en = 1'b0;

    always @(posedge CLOCK_50) cyc++;

    always @(negedge CLOCK_50) begin
        if (prev_en && !LCD_EN) mon_q.push_back('{LCD_RS, LCD_DATA, cyc});
        prev_en = LCD_EN;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         gap;   // clocks since release (first) or since previous byte
    } init_t;

    typedef struct {
        logic [31:0]  pc;
        logic [7:0]   sel;
        logic [31:0]  data;
        logic [127:0] l1;
        logic [127:0] l2;
    } vec_t;

    init_t init_tbl[4];
    vec_t  vecs[3];

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge CLOCK_50);
            n++;
        end
        check({name, " reaches idle"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_req();
        @(negedge CLOCK_50);
        upd_req = 1'b1;
        @(negedge CLOCK_50);
        upd_req = 1'b0;
    endtask

    task automatic check_init(input string name, input int rel);
        int n    = 0;
        int prev = rel;
        while (!ready && n < 300) begin
            @(negedge CLOCK_50);
            n++;
        end
        check({name, " ready"}, 32'(ready), 32'd1);
        check({name, " init count"}, 32'(mon_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < mon_q.size()) begin
                check($sformatf("%s init%0d data", name, i), 32'(mon_q[i].data), 32'(init_tbl[i].data));
                check($sformatf("%s init%0d rs", name, i), 32'(mon_q[i].rs), 32'd0);
                check($sformatf("%s init%0d gap", name, i), 32'(mon_q[i].cyc - prev), 32'(init_tbl[i].gap));
                prev = mon_q[i].cyc;
            end
        end
    endtask

    task automatic check_redraw(input string name, input int base,
                                input logic [127:0] l1, input logic [127:0] l2);
        logic [127:0] s;
        logic [8:0]   e;
        for (int i = 0; i < 34; i++) begin
            if (i == 0) begin
                e = {1'b0, 8'h80};
            end else if (i < 17) begin
                s = l1 << (8 * (i - 1));
                e = {1'b1, s[127:120]};
            end else if (i == 17) begin
                e = {1'b0, 8'hC0};
            end else begin
                s = l2 << (8 * (i - 18));
                e = {1'b1, s[127:120]};
            end
            if (base + i < mon_q.size()) begin
                check($sformatf("%s byte%0d", name, i),
                      32'({mon_q[base + i].rs, mon_q[base + i].data}), 32'(e));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;
        int n;

        init_tbl[0] = '{8'h38, 13};
        init_tbl[1] = '{8'h0C, 7};
        init_tbl[2] = '{8'h01, 7};
        init_tbl[3] = '{8'h06, 11};

        vecs[0] = '{32'h0040001C, 8'h07, 32'h0040001C, "PC 0040001C     ", "S07: 0040001C   "};
        vecs[1] = '{32'h0040001C, 8'h0B, 32'hDEADBEEF, "PC 0040001C     ", "S0B: DEADBEEF   "};
        vecs[2] = '{32'h89ABCDEF, 8'h9A, 32'h76543210, "PC 89ABCDEF     ", "S9A: 76543210   "};

        SYS_reset = 1'b1;
        upd_req   = 1'b0;
        DATA      = '0;
        PC        = '0;
        SEL       = '0;

        // ---- reset state ----
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst LCD_EN", 32'(LCD_EN), 32'd0);
        check("rst LCD_DATA", 32'(LCD_DATA), 32'd0);
        check("rst LCD_RS", 32'(LCD_RS), 32'd0);
        check("rst LCD_RW", 32'(LCD_RW), 32'd0);
        check("rst busy", 32'(busy), 32'd1);
        check("rst ready", 32'(ready), 32'd0);

        // ---- test 1: power-up wait and init sequence ----
        @(negedge CLOCK_50);
        mon_q.delete();
        SYS_reset = 1'b0;
        rel = cyc;
        check_init("t1", rel);
        check("t1 idle busy", 32'(busy), 32'd0);

        // ---- tests 2/3: table-driven redraws ----
        foreach (vecs[k]) begin
            mon_q.delete();
            PC   = vecs[k].pc;
            SEL  = vecs[k].sel;
            DATA = vecs[k].data;
            pulse_req();
            check($sformatf("v%0d busy", k), 32'(busy), 32'd1);
            wait_idle($sformatf("v%0d", k), 1000);
            check($sformatf("v%0d count", k), 32'(mon_q.size()), 32'd34);
            check_redraw($sformatf("v%0d", k), 0, vecs[k].l1, vecs[k].l2);
        end

        // ---- test 4: inputs change every clock after the snapshot ----
        mon_q.delete();
        PC   = 32'h11111111;
        DATA = 32'h22222222;
        SEL  = 8'h33;
        pulse_req();
        n = 0;
        while (busy && n < 1000) begin
            @(negedge CLOCK_50);
            PC   = $urandom;
            DATA = $urandom;
            SEL  = 8'($urandom);
            n++;
        end
        check("t4 reaches idle", 32'(busy), 32'd0);
        check("t4 count", 32'(mon_q.size()), 32'd34);
        check_redraw("t4", 0, "PC 11111111     ", "S33: 22222222   ");

        // ---- test 5: three requests during a redraw collapse into one ----
        mon_q.delete();
        PC   = 32'hA5A50F0F;
        DATA = 32'h0000FFFF;
        SEL  = 8'hF0;
        pulse_req();
        repeat (40) @(negedge CLOCK_50);
        for (int p = 0; p < 3; p++) begin
            pulse_req();
            repeat (10) @(negedge CLOCK_50);
        end
        wait_idle("t5", 2000);
        check("t5 count", 32'(mon_q.size()), 32'd68);
        check_redraw("t5 second", 34, "PC A5A50F0F     ", "SF0: 0000FFFF   ");
        repeat (30) @(negedge CLOCK_50);
        check("t5 no third redraw", 32'(mon_q.size()), 32'd68);
        check("t5 stays idle", 32'(busy), 32'd0);

        // ---- test 6: reset during a character strobe ----
        pulse_req();
        n = 0;
        while (!(LCD_EN && LCD_RS) && n < 300) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("t6 char strobe seen", 32'(LCD_EN & LCD_RS), 32'd1);
        SYS_reset = 1'b1;
        @(negedge CLOCK_50);
        check("t6 EN after reset", 32'(LCD_EN), 32'd0);
        check("t6 busy after reset", 32'(busy), 32'd1);
        check("t6 ready after reset", 32'(ready), 32'd0);
        check("t6 DATA after reset", 32'(LCD_DATA), 32'd0);
        @(negedge CLOCK_50);
        mon_q.delete();
        SYS_reset = 1'b0;
        rel = cyc;
        // A request during the power-up wait is remembered and served after init.
        PC   = 32'h00000009;
        DATA = 32'h0000000A;
        SEL  = 8'h9F;
        pulse_req();
        check_init("t6", rel);
        wait_idle("t6 redraw", 1000);
        check("t6 count", 32'(mon_q.size()), 32'd38);
        check_redraw("t6", 4, "PC 00000009     ", "S9F: 0000000A   ");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
